// File: rtl/vga_plot_sink.sv
// Pixel-plot sink: captures plots into a WIDTH x HEIGHT x 3-bit frame store,
// bulk-clears it, and streams it back in raster order over valid/ready.
module vga_plot_sink #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       vga_x,
  input  logic [6:0]       vga_y,
  input  logic [2:0]       vga_colour,
  input  logic             vga_plot,
  input  logic             clear,
  input  logic [2:0]       clear_colour,
  input  logic             start,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_x,
  output logic [6:0]       out_y,
  output logic [2:0]       out_colour,
  output logic             out_last,
  output logic [CNT_W-1:0] plot_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int              DEPTH  = WIDTH * HEIGHT;
  localparam int              AW     = $clog2(DEPTH);
  localparam logic [AW-1:0]   A_LAST = AW'(DEPTH - 1);
  localparam logic [7:0]      X_LIM  = 8'(WIDTH);
  localparam logic [7:0]      X_LAST = 8'(WIDTH - 1);
  localparam logic [6:0]      Y_LIM  = 7'(HEIGHT);
  localparam logic [6:0]      Y_LAST = 7'(HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SCAN} state_t;

  state_t r_state, w_next;

  logic [2:0]       r_mem [DEPTH];
  logic [2:0]       r_rd_data;

  logic [AW-1:0]    r_clr_addr;
  logic [2:0]       r_clr_colour;

  logic [AW-1:0]    r_rd_addr;
  logic [7:0]       r_sx;
  logic [6:0]       r_sy;
  logic             r_iss_done;

  logic             r_s1_valid;
  logic [7:0]       r_s1_x;
  logic [6:0]       r_s1_y;
  logic             r_s1_last;

  logic             r_out_valid;
  logic [7:0]       r_out_x;
  logic [6:0]       r_out_y;
  logic [2:0]       r_out_colour;
  logic             r_out_last;

  logic [CNT_W-1:0] r_plot_count;
  logic [CNT_W-1:0] r_drop_count;

  logic             w_in_range, w_plot_ok, w_plot_drop;
  logic [AW-1:0]    w_plot_addr;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [2:0]       w_wdata;
  logic             w_adv, w_rd_en, w_xfer_last, w_iss_last;

  assign w_in_range  = (vga_x < X_LIM) && (vga_y < Y_LIM);
  assign w_plot_ok   = vga_plot && w_in_range && (r_state != S_CLEAR);
  assign w_plot_drop = vga_plot && !w_plot_ok;
  assign w_plot_addr = AW'(vga_y) * AW'(WIDTH) + AW'(vga_x);

  // Single write port: the clear sweep owns it in CLEAR, plots otherwise.
  assign w_we    = (r_state == S_CLEAR) || w_plot_ok;
  assign w_waddr = (r_state == S_CLEAR) ? r_clr_addr   : w_plot_addr;
  assign w_wdata = (r_state == S_CLEAR) ? r_clr_colour : vga_colour;

  // The two-stage read pipeline advances whenever the output slot is free.
  assign w_adv       = !r_out_valid || out_ready;
  assign w_rd_en     = (r_state == S_SCAN) && w_adv;
  assign w_xfer_last = r_out_valid && out_ready && r_out_last;
  assign w_iss_last  = (r_sx == X_LAST) && (r_sy == Y_LAST);

  // NOTE: the frame store has no reset; its contents deliberately survive rst
  // and a resettable array would not map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    if (w_rd_en) r_rd_data <= r_mem[r_rd_addr];
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // sees pre-edge values, which also gives read-first on a same-address plot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: w_next gets its default before the case so no path infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (clear)      w_next = S_CLEAR;
        else if (start) w_next = S_SCAN;
      end
      S_CLEAR: if (r_clr_addr == A_LAST) w_next = S_IDLE;
      S_SCAN:  if (w_xfer_last)          w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_addr   <= '0;
      r_clr_colour <= '0;
      r_rd_addr    <= '0;
      r_sx         <= '0;
      r_sy         <= '0;
      r_iss_done   <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_s1_x       <= '0;
      r_s1_y       <= '0;
      r_s1_last    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_x      <= '0;
      r_out_y      <= '0;
      r_out_colour <= '0;
      r_out_last   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_clr_addr  <= '0;
          r_rd_addr   <= '0;
          r_sx        <= '0;
          r_sy        <= '0;
          r_iss_done  <= 1'b0;
          r_s1_valid  <= 1'b0;
          r_s1_last   <= 1'b0;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          if (clear) r_clr_colour <= clear_colour;
        end
        S_CLEAR: r_clr_addr <= r_clr_addr + 1'b1;
        S_SCAN: begin
          if (w_adv) begin
            r_s1_valid   <= !r_iss_done;
            r_s1_x       <= r_sx;
            r_s1_y       <= r_sy;
            r_s1_last    <= !r_iss_done && w_iss_last;
            r_out_valid  <= r_s1_valid;
            r_out_x      <= r_s1_x;
            r_out_y      <= r_s1_y;
            r_out_colour <= r_rd_data;
            r_out_last   <= r_s1_last;
            if (!r_iss_done) begin
              if (w_iss_last) begin
                r_iss_done <= 1'b1;
              end else begin
                r_rd_addr <= r_rd_addr + 1'b1;
                if (r_sx == X_LAST) begin
                  r_sx <= '0;
                  r_sy <= r_sy + 1'b1;
                end else begin
                  r_sx <= r_sx + 1'b1;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating counters, cleared only by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_plot_count <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_plot_ok && (r_plot_count != '1))   r_plot_count <= r_plot_count + 1'b1;
      if (w_plot_drop && (r_drop_count != '1)) r_drop_count <= r_drop_count + 1'b1;
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign out_valid  = r_out_valid;
  assign out_x      = r_out_x;
  assign out_y      = r_out_y;
  assign out_colour = r_out_colour;
  assign out_last   = r_out_last;
  assign plot_count = r_plot_count;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_vga_plot_sink.sv
// Directed self-checking bench for vga_plot_sink: reset, clear, plots,
// full-speed and stalled scans, clear/start collisions and async reset.
module tb_vga_plot_sink;

  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  vga_x = '0;
  logic [6:0]  vga_y = '0;
  logic [2:0]  vga_colour = '0;
  logic        vga_plot = 1'b0;
  logic        clear = 1'b0;
  logic [2:0]  clear_colour = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_x;
  logic [6:0]  out_y;
  logic [2:0]  out_colour;
  logic        out_last;
  logic [15:0] plot_count;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] exp_mem [N];

  vga_plot_sink #(.WIDTH(W), .HEIGHT(H), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .clear(clear), .clear_colour(clear_colour), .start(start),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_colour(out_colour), .out_last(out_last),
    .plot_count(plot_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic plot(input int x, input int y, input logic [2:0] c);
    vga_x = 8'(x);
    vga_y = 7'(y);
    vga_colour = c;
    vga_plot = 1'b1;
    tick();
    vga_plot = 1'b0;
    if (x < W && y < H) exp_mem[y * W + x] = c;
  endtask

  // Full raster scan compared against the bench frame model.
  task automatic run_scan(input bit toggle, input string tag);
    int k, cyc, bad, stall_bad, gaps;
    bit stalled;
    logic [7:0] hx;
    logic [6:0] hy;
    logic [2:0] hc;
    logic       hl;
    k = 0; cyc = 0; bad = 0; stall_bad = 0; gaps = 0; stalled = 0;
    hx = '0; hy = '0; hc = '0; hl = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_valid_after_1"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    tick();
    check({tag, "_valid_after_2"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_valid_after_3"}, 32'(out_valid), 32'd1);
    while (k < N && cyc < 45000) begin
      out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (out_valid) begin
        if (stalled && (out_x !== hx || out_y !== hy || out_colour !== hc || out_last !== hl))
          stall_bad++;
        if (out_x !== 8'(k % W) || out_y !== 7'(k / W) || out_colour !== exp_mem[k] ||
            out_last !== (k == N - 1))
          bad++;
        if (out_ready) begin
          if (k == 0) begin
            check({tag, "_first_colour"}, 32'(out_colour), 32'(exp_mem[0]));
            check({tag, "_first_last"}, 32'(out_last), 32'd0);
          end
          if (k == N - 1) begin
            check({tag, "_final_xy"}, {out_x, 1'b0, out_y}, {8'(W - 1), 1'b0, 7'(H - 1)});
            check({tag, "_final_colour"}, 32'(out_colour), 32'(exp_mem[N - 1]));
            check({tag, "_final_last"}, 32'(out_last), 32'd1);
          end
          k++;
          stalled = 0;
        end else begin
          stalled = 1;
          hx = out_x; hy = out_y; hc = out_colour; hl = out_last;
        end
      end else begin
        gaps++;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check({tag, "_transfers"}, 32'(k), 32'(N));
    check({tag, "_pixel_errs"}, 32'(bad), 32'd0);
    check({tag, "_stall_errs"}, 32'(stall_bad), 32'd0);
    check({tag, "_valid_gaps"}, 32'(gaps), 32'd0);
    check({tag, "_valid_done"}, 32'(out_valid), 32'd0);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt, idle_bad;

    // 1: reset held with plot and start active
    vga_x = 8'd5; vga_y = 7'd5; vga_colour = 3'b111;
    vga_plot = 1'b1; start = 1'b1;
    repeat (4) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_out_xyc", {out_x, out_y, out_colour}, 32'd0);
    check("rst_plot_cnt", 32'(plot_count), 32'd0);
    check("rst_drop_cnt", 32'(drop_count), 32'd0);
    vga_plot = 1'b0; start = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // 2+5: clear and start together, start pulse and plot during the sweep
    for (int i = 0; i < N; i++) exp_mem[i] = 3'b000;
    clear_colour = 3'b000;
    clear = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    vga_x = 8'd10; vga_y = 7'd10; vga_colour = 3'b111;
    cnt = 0;
    while (busy && cnt < 30000) begin
      cnt++;
      start = (cnt == 100);
      vga_plot = (cnt == 200);
      tick();
    end
    start = 1'b0; vga_plot = 1'b0;
    check("clear_busy_cycles", 32'(cnt), 32'(N));
    idle_bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy || out_valid) idle_bad++;
      tick();
    end
    check("no_scan_after_clear", 32'(idle_bad), 32'd0);
    check("clear_drop_cnt", 32'(drop_count), 32'd1);
    check("clear_plot_cnt", 32'(plot_count), 32'd0);

    plot(0, 0, 3'b101);
    plot(159, 119, 3'b010);
    plot(160, 5, 3'b111);
    plot(3, 120, 3'b111);
    check("plots_plot_cnt", 32'(plot_count), 32'd2);
    check("plots_drop_cnt", 32'(drop_count), 32'd3);

    // 3: full-speed scan
    run_scan(1'b0, "scan_fast");

    // 6: async reset mid-scan, away from the clock edge
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (500) tick();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_plot_cnt", 32'(plot_count), 32'd0);
    check("async_rst_drop_cnt", 32'(drop_count), 32'd0);
    out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);

    // 4: stalled scan after reset; frame must match pre-reset contents
    run_scan(1'b1, "scan_stall");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_plot_sink.md
Name: vga_plot_sink

Overview:
Receiving end of the VGA pixel-plot interface (x, y, colour, plot strobe) driven by the fillscreen and circle drawing engines. Captures plotted pixels into an internal 160x120x3 frame store and, on request, streams the whole frame back out in raster order over a valid/ready handshake. Used as a simulation and on-chip checker, and as a frame-store stand-in behind the drawing engines. Also provides a bulk clear and plot/drop counters.

Parameters:
WIDTH, 160, frame width in pixels
HEIGHT, 120, frame height in pixels
CNT_W, 16, width of plot_count and drop_count

Ports:
clk  in  1  system clock; all logic rising-edge
rst  in  1  asynchronous reset, active-high
vga_x  in  8  plot x coordinate
vga_y  in  7  plot y coordinate
vga_colour  in  3  plot colour
vga_plot  in  1  plot strobe; one pixel per cycle high
clear  in  1  single-cycle request to fill frame with clear_colour
clear_colour  in  3  fill colour, sampled with clear
start  in  1  single-cycle request to scan frame out
busy  out  1  high in CLEAR or SCAN
out_valid  out  1  scan pixel valid
out_ready  in  1  downstream accepts pixel
out_x  out  8  scan pixel x
out_y  out  7  scan pixel y
out_colour  out  3  scan pixel colour
out_last  out  1  high with pixel (WIDTH-1, HEIGHT-1)
plot_count  out  CNT_W  accepted plots, saturating
drop_count  out  CNT_W  rejected plots, saturating

Behaviour:
- Reset (async, immediate): state IDLE; busy, out_valid, out_last = 0; out_x, out_y, out_colour = 0; both counters = 0. Frame store contents are NOT cleared by reset.
- Frame store: WIDTH*HEIGHT entries x 3 bits, address = y*WIDTH + x. One write port (plot or clear) and one read port (scan).
- States: IDLE, CLEAR, SCAN.
- IDLE:
  - clear=1 -> CLEAR, latch clear_colour.
  - start=1 with clear=0 -> SCAN.
  - clear and start in the same cycle: clear wins; start is discarded, not queued.
- CLEAR:
  - Writes one address per cycle, 0 up to WIDTH*HEIGHT-1, so busy stays high exactly WIDTH*HEIGHT cycles.
  - Returns to IDLE after the final write.
  - clear and start are ignored.
- SCAN:
  - Reads addresses in raster order: x fastest, then y.
  - First out_valid asserts exactly 2 cycles after start is sampled.
  - A transfer occurs when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_x, out_y, out_colour and out_last hold stable.
  - No pixel is skipped or duplicated.
  - After the transfer with out_last=1: out_valid drops the next cycle, busy drops, state returns to IDLE.
  - clear and start are ignored during SCAN.
- Plot handling:
  - In IDLE or SCAN, vga_plot=1 with vga_x < WIDTH and vga_y < HEIGHT writes vga_colour at the addressed pixel and increments plot_count.
  - Otherwise, with vga_plot=1 (out-of-range coordinates, or any plot during CLEAR): no write; drop_count increments.
  - Plot and scan read to the same address in the same cycle: scan returns the value stored before that cycle's write (read-first).
  - Counters saturate at 2^CNT_W-1; they are never cleared except by rst.
- Reset mid-CLEAR leaves the frame partially filled; reset mid-SCAN drops the transfer in progress. Both return to IDLE.

Test Plan:
1. Assert rst with vga_plot=1 and start=1 -> all outputs 0, busy 0, no counter movement while rst is high.
2. clear with clear_colour=3'b000 -> busy high exactly 19200 cycles. Then plot (0,0,3'b101), (159,119,3'b010), (160,5,3'b111), (3,120,3'b111) -> plot_count=2, drop_count=2.
3. start with out_ready=1 -> out_valid first high 2 cycles after start; 19200 consecutive transfers. Pixel (0,0) colour 3'b101; pixel (159,119) colour 3'b010 with out_last=1; all other pixels 3'b000; busy low the cycle after the last transfer.
4. Scan with out_ready toggling 1/0 every cycle -> outputs stable while stalled; 19200 transfers in raster order with no loss; out_last only on (159,119).
5. clear and start in the same cycle, plus a start pulse and a plot mid-clear -> only CLEAR runs (19200 busy cycles), no scan follows, drop_count +1 for the mid-clear plot.
6. Assert rst asynchronously mid-SCAN (between clock edges) -> out_valid and busy fall immediately, counters read 0. A new start then scans frame contents identical to those before reset.
